fifo_stream_reader: RTL and testbench
=====================================

Name: fifo_stream_reader

Overview:
- Read-side controller for parameterized_fifo.
- On a start command it pops exactly burst_len words from the FIFO read port (read_en/dout/empty).
- Delivers the words in order on a valid/ready output stream through a 2-entry output buffer that absorbs the FIFO's 1-cycle registered read latency.
- Pulses done when the last word is accepted downstream; the consumer end of the same FIFO that the writer path fills.

Parameters:
- DATA_WIDTH, 8, width of FIFO data and m_data.
- LEN_WIDTH, 8, width of burst_len and words_sent; max burst is 2^LEN_WIDTH-1 words.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  one-cycle burst request; sampled only in IDLE.
- burst_len  input  LEN_WIDTH  number of words to pop; latched with start.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when the burst completes.
- words_sent  output  LEN_WIDTH  count of output handshakes in the current/last burst.
- fifo_empty  input  1  FIFO empty flag.
- fifo_dout  input  DATA_WIDTH  FIFO read data; valid the cycle after an accepted read.
- fifo_read_en  output  1  FIFO pop request.
- m_data  output  DATA_WIDTH  output stream data.
- m_valid  output  1  output stream valid.
- m_ready  input  1  output stream ready.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; buffer cleared; in-flight flag cleared.
  - Outputs: m_valid=0, m_data=0, busy=0, done=0, words_sent=0, fifo_read_en=0.
  - Reset mid-burst discards buffered words and any in-flight FIFO word; it is not replayed.
- FSM states IDLE, RUN, DONE.
  - IDLE: start=1 at an edge latches burst_len into len_q and clears issued, words_sent and buffer, then moves to RUN. If burst_len=0, it moves to DONE instead.
  - RUN: busy=1. Moves to DONE at the edge where words_sent reaches len_q, i.e. the final handshake.
  - DONE: done=1 and busy=0 for exactly one cycle, then IDLE. words_sent holds its value until the next accepted start.
- start is ignored in RUN and DONE.
- FIFO read timing: a read is accepted at an edge where fifo_read_en=1 and fifo_empty=0.
  - fifo_dout is valid during the following cycle.
  - It is written into the output buffer at the next edge; the in-flight flag covers that cycle.
- Pop rule (combinational): fifo_read_en = (state==RUN) & !fifo_empty & (issued<len_q) & (occ + inflight - pop < 2).
  - occ is buffer occupancy (0..2); inflight is 0/1; pop = m_valid & m_ready.
  - Never asserted while fifo_empty=1, so FIFO underflow is impossible.
- issued increments on every accepted read; never exceeds len_q.
- Output buffer: 2-entry FIFO with m_valid = (occ != 0) and m_data = head entry.
  - m_data holds stable while m_valid=1 and m_ready=0.
  - m_data returns to its previous value only via the next write; with occ=0 it holds the last value.
  - Simultaneous write and pop keeps occ unchanged. Order is strictly preserved.
- Latency: with start accepted at edge N, FIFO non-empty and m_ready=1:
  - fifo_read_en=1 in cycle N..N+1.
  - The first word appears on m_valid after edge N+2.
  - Sustained throughput is 1 word/cycle.
- FIFO goes empty mid-burst: reads stall and m_valid drops once the buffer drains. Reads resume in the cycle after fifo_empty falls. No timeout.
- words_sent increments per handshake and wraps only through a new start (it clears).

Test Plan:
- Write 0x00..0x06 into parameterized_fifo, start with burst_len=7, m_ready=1 -> m_data 0x00..0x06 on 7 consecutive cycles starting 2 cycles after start; done pulses once; words_sent=7; FIFO empty=1.
- Same data, m_ready toggling 1,0,0,1,... -> all 7 words in order with no duplicates; m_data stable during stalls; occ+inflight never exceeds 2; fifo_read_en never high with fifo_empty=1.
- Preload 2 words, burst_len=4; write 2 more 10 cycles later -> 2 words out, then m_valid=0 and busy=1 stall; remaining 2 delivered; done pulses after the 4th; words_sent=4.
- burst_len=0 -> no fifo_read_en; done=1 the cycle after start; busy stays 0; words_sent=0.
- Assert start again during RUN -> ignored; burst completes with the original length.
- Drive reset=0 asynchronously mid-burst (after 3 of 7 words) -> all outputs 0 immediately. After release, a new burst of 4 returns the next 4 FIFO words (0x04 dropped in flight is acceptable only if it was already popped; check against the FIFO pop count).

Source files
------------

// File: rtl/fifo_stream_reader.sv
// Read-side burst controller: pops burst_len words from a registered-output FIFO
// and replays them on a valid/ready stream through a 2-entry skid buffer.
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  burst_len,
    output logic                  busy,
    output logic                  done,
    output logic [LEN_WIDTH-1:0]  words_sent,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_read_en,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [LEN_WIDTH-1:0] ONE = LEN_WIDTH'(1);

    state_t                state, state_nxt;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  issued;
    logic [DATA_WIDTH-1:0] head_q;
    logic [DATA_WIDTH-1:0] tail_q;
    logic [1:0]            occ;
    logic                  inflight;
    logic                  pop;
    logic                  last_hs;
    logic                  accept;
    logic [2:0]            fill;

    assign pop     = m_valid & m_ready;
    assign last_hs = pop && ((words_sent + ONE) == len_q);
    assign accept  = (state == IDLE) && start;
    assign fill    = {1'b0, occ} + {2'b00, inflight};
    assign m_valid = (occ != 2'd0);
    assign m_data  = head_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (burst_len == '0) ? DONE : RUN;
            RUN:     if (last_hs) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Reads are allowed only while the word can still land in the buffer,
    // counting the in-flight word and any slot freed by this cycle's pop.
    always_comb begin
        busy         = (state == RUN);
        done         = (state == DONE);
        fifo_read_en = (state == RUN) && !fifo_empty && (issued < len_q) &&
                       (fill < (3'd2 + {2'b00, pop}));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_q      <= '0;
            issued     <= '0;
            words_sent <= '0;
            inflight   <= 1'b0;
            occ        <= 2'd0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            inflight <= fifo_read_en;
            if (accept) begin
                len_q      <= burst_len;
                issued     <= '0;
                words_sent <= '0;
                occ        <= 2'd0;
            end else begin
                if (fifo_read_en) issued <= issued + ONE;
                if (pop)          words_sent <= words_sent + ONE;
                // head_q only changes on a write or a shift, so it holds the
                // last delivered word once the buffer drains.
                case ({inflight, pop})
                    2'b10: begin
                        occ <= occ + 2'd1;
                        if (occ == 2'd0) head_q <= fifo_dout;
                        else             tail_q <= fifo_dout;
                    end
                    2'b01: begin
                        occ <= occ - 2'd1;
                        if (occ == 2'd2) head_q <= tail_q;
                    end
                    2'b11: begin
                        if (occ == 2'd2) begin
                            head_q <= tail_q;
                            tail_q <= fifo_dout;
                        end else begin
                            head_q <= fifo_dout;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: behavioural FIFO plus a queue model of FIFO
// contents; each burst must deliver the next words of that model in order.
module tb_fifo_stream_reader;
    localparam int DW = 8;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [LW-1:0] burst_len;
    logic          busy, done, m_valid, m_ready;
    logic [LW-1:0] words_sent;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_dout = '0;
    logic          fifo_read_en;
    logic [DW-1:0] m_data;

    always #5 clk = ~clk;

    fifo_stream_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .reset(reset), .start(start), .burst_len(burst_len),
        .busy(busy), .done(done), .words_sent(words_sent),
        .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .fifo_read_en(fifo_read_en),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready)
    );

    int n_cmp = 0;
    int n_fail = 0;
    logic [DW-1:0] fq[$];   // FIFO storage
    logic [DW-1:0] wq[$];   // pending writes, applied at the next edge
    logic [DW-1:0] mq[$];   // model: words not yet consumed by the reader
    logic [DW-1:0] rx[$];
    int rx_cyc[$];
    int pop_cnt = 0, hs_cnt = 0, lost = 0, cyc = 0;
    int done_cnt = 0, last_done_cyc = -1, busy_cyc = 0, rd_cyc = 0;
    int uf_err = 0, stab_err = 0, ovf_err = 0;
    int rdy_mode = 0, rdy_phase = 0;
    logic prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;

    // Behavioural FIFO with registered read data
    always @(posedge clk) begin
        if (fifo_read_en && !fifo_empty) begin
            fifo_dout <= fq.pop_front();
            pop_cnt   <= pop_cnt + 1;
        end
        while (wq.size() > 0) fq.push_back(wq.pop_front());
        fifo_empty <= (fq.size() == 0);
    end

    // Ready driver at negedge, monitor sampling just before the next posedge
    always @(negedge clk) begin
        case (rdy_mode)
            0:       m_ready = 1'b1;
            1:       begin m_ready = (rdy_phase % 3 == 0); rdy_phase++; end
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
        #4;
        if (reset) begin
            if (pop_cnt - hs_cnt - lost > 2) ovf_err++;
            if (prev_stall && (!m_valid || m_data !== prev_data)) stab_err++;
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            if (fifo_read_en && fifo_empty) uf_err++;
            if (m_valid && m_ready) begin
                rx.push_back(m_data);
                rx_cyc.push_back(cyc);
                hs_cnt++;
            end
            if (done) begin done_cnt++; last_done_cyc = cyc; end
            if (busy) busy_cyc++;
            if (fifo_read_en) rd_cyc++;
        end else begin
            prev_stall = 1'b0;
        end
        cyc++;
    end

    task automatic push(input logic [DW-1:0] v);
        wq.push_back(v);
        mq.push_back(v);
    endtask

    task automatic start_burst(input int len, output int c0);
        @(negedge clk);
        start = 1'b1;
        burst_len = LW'(len);
        c0 = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget, input string name);
        for (int i = 0; i < budget && done_cnt == d0; i++) @(negedge clk);
        n_cmp++;
        if (done_cnt == d0) begin
            n_fail++;
            $display("FAIL %s_timeout: done count %0d, required > %0d", name, done_cnt, d0);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; burst_len = '0; rdy_mode = 0;
        repeat (2) @(negedge clk);
        n_cmp++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
        n_cmp++; if (m_data !== '0) begin n_fail++; $display("FAIL reset_m_data: got %h want 00", m_data); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (words_sent !== '0) begin n_fail++; $display("FAIL reset_words_sent: got %0d want 0", words_sent); end
        n_cmp++; if (fifo_read_en !== 1'b0) begin n_fail++; $display("FAIL reset_read_en: got %b want 0", fifo_read_en); end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int c0, d0, h0;
        logic [DW-1:0] e;
        rdy_mode = 0;
        for (int i = 0; i < 7; i++) push(DW'(i));
        repeat (2) @(negedge clk);
        d0 = done_cnt; h0 = rx.size();
        start_burst(7, c0);
        wait_done(d0, 100, "basic");
        @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            e = mq.pop_front();
            n_cmp++;
            if (h0 + i >= rx.size() || rx[h0+i] !== e) begin
                n_fail++; $display("FAIL basic_data[%0d]: got %h want %h", i, (h0 + i < rx.size()) ? rx[h0+i] : 'x, e);
            end
            n_cmp++;
            if (h0 + i >= rx_cyc.size() || rx_cyc[h0+i] != c0 + 3 + i) begin
                n_fail++; $display("FAIL basic_cycle[%0d]: got %0d want %0d", i, (h0 + i < rx_cyc.size()) ? rx_cyc[h0+i] - c0 : -1, 3 + i);
            end
        end
        n_cmp++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL basic_done_pulses: got %0d want 1", done_cnt - d0); end
        n_cmp++; if (last_done_cyc != c0 + 10) begin n_fail++; $display("FAIL basic_done_cycle: got %0d want %0d", last_done_cyc - c0, 10); end
        n_cmp++; if (words_sent !== LW'(7)) begin n_fail++; $display("FAIL basic_words_sent: got %0d want 7", words_sent); end
        n_cmp++; if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL basic_fifo_empty: got %b want 1", fifo_empty); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after: got %b want 0", busy); end
    endtask

    task automatic test_stall();
        int c0, d0, h0;
        logic [DW-1:0] e;
        rdy_mode = 1; rdy_phase = 0;
        for (int i = 0; i < 7; i++) push(8'($urandom));
        repeat (2) @(negedge clk);
        d0 = done_cnt; h0 = rx.size();
        start_burst(7, c0);
        wait_done(d0, 200, "stall");
        n_cmp++; if (rx.size() - h0 != 7) begin n_fail++; $display("FAIL stall_count: got %0d want 7", rx.size() - h0); end
        for (int i = 0; i < 7; i++) begin
            e = mq.pop_front();
            n_cmp++;
            if (h0 + i >= rx.size() || rx[h0+i] !== e) begin
                n_fail++; $display("FAIL stall_data[%0d]: got %h want %h", i, (h0 + i < rx.size()) ? rx[h0+i] : 'x, e);
            end
        end
        n_cmp++; if (words_sent !== LW'(7)) begin n_fail++; $display("FAIL stall_words_sent: got %0d want 7", words_sent); end
        rdy_mode = 0;
    endtask

    task automatic test_empty_stall();
        int c0, d0, h0;
        logic [DW-1:0] e;
        rdy_mode = 0;
        push(8'($urandom)); push(8'($urandom));
        repeat (2) @(negedge clk);
        d0 = done_cnt; h0 = rx.size();
        start_burst(4, c0);
        repeat (10) @(negedge clk);
        n_cmp++; if (rx.size() - h0 != 2) begin n_fail++; $display("FAIL empty_partial_count: got %0d want 2", rx.size() - h0); end
        n_cmp++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL empty_m_valid: got %b want 0", m_valid); end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL empty_busy: got %b want 1", busy); end
        n_cmp++; if (done_cnt != d0) begin n_fail++; $display("FAIL empty_early_done: got %0d want %0d", done_cnt, d0); end
        push(8'($urandom)); push(8'($urandom));
        wait_done(d0, 100, "empty");
        for (int i = 0; i < 4; i++) begin
            e = mq.pop_front();
            n_cmp++;
            if (h0 + i >= rx.size() || rx[h0+i] !== e) begin
                n_fail++; $display("FAIL empty_data[%0d]: got %h want %h", i, (h0 + i < rx.size()) ? rx[h0+i] : 'x, e);
            end
        end
        n_cmp++; if (words_sent !== LW'(4)) begin n_fail++; $display("FAIL empty_words_sent: got %0d want 4", words_sent); end
    endtask

    task automatic test_zero_len();
        int c0, d0, r0, b0;
        push(8'($urandom));
        repeat (2) @(negedge clk);
        d0 = done_cnt; r0 = rd_cyc; b0 = busy_cyc;
        start_burst(0, c0);
        repeat (3) @(negedge clk);
        n_cmp++; if (rd_cyc != r0) begin n_fail++; $display("FAIL zero_read_en: got %0d cycles want 0", rd_cyc - r0); end
        n_cmp++; if (busy_cyc != b0) begin n_fail++; $display("FAIL zero_busy: got %0d cycles want 0", busy_cyc - b0); end
        n_cmp++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL zero_done_pulses: got %0d want 1", done_cnt - d0); end
        n_cmp++; if (last_done_cyc != c0 + 1) begin n_fail++; $display("FAIL zero_done_cycle: got %0d want 1", last_done_cyc - c0); end
        n_cmp++; if (words_sent !== '0) begin n_fail++; $display("FAIL zero_words_sent: got %0d want 0", words_sent); end
    endtask

    task automatic test_restart_ignored();
        int c0, d0, h0;
        logic [DW-1:0] e;
        for (int i = 0; i < 4; i++) push(8'($urandom));
        repeat (2) @(negedge clk);
        d0 = done_cnt; h0 = rx.size();
        start_burst(3, c0);
        @(negedge clk);
        start = 1'b1; burst_len = LW'(9);
        @(negedge clk);
        start = 1'b0;
        wait_done(d0, 100, "restart");
        repeat (3) @(negedge clk);
        n_cmp++; if (rx.size() - h0 != 3) begin n_fail++; $display("FAIL restart_count: got %0d want 3", rx.size() - h0); end
        for (int i = 0; i < 3; i++) begin
            e = mq.pop_front();
            n_cmp++;
            if (h0 + i >= rx.size() || rx[h0+i] !== e) begin
                n_fail++; $display("FAIL restart_data[%0d]: got %h want %h", i, (h0 + i < rx.size()) ? rx[h0+i] : 'x, e);
            end
        end
        n_cmp++; if (words_sent !== LW'(3)) begin n_fail++; $display("FAIL restart_words_sent: got %0d want 3", words_sent); end
        n_cmp++; if (fq.size() != mq.size()) begin n_fail++; $display("FAIL restart_fifo_left: got %0d want %0d", fq.size(), mq.size()); end
    endtask

    task automatic test_random();
        int c0, d0, h0, len;
        logic [DW-1:0] e;
        rdy_mode = 2;
        for (int it = 0; it < 4; it++) begin
            len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) push(8'($urandom));
            repeat (2) @(negedge clk);
            d0 = done_cnt; h0 = rx.size();
            start_burst(len, c0);
            wait_done(d0, 300, "random");
            for (int i = 0; i < len; i++) begin
                e = mq.pop_front();
                n_cmp++;
                if (h0 + i >= rx.size() || rx[h0+i] !== e) begin
                    n_fail++; $display("FAIL random%0d_data[%0d]: got %h want %h", it, i, (h0 + i < rx.size()) ? rx[h0+i] : 'x, e);
                end
            end
            n_cmp++; if (words_sent !== LW'(len)) begin n_fail++; $display("FAIL random%0d_words_sent: got %0d want %0d", it, words_sent, len); end
        end
        rdy_mode = 0;
    endtask

    task automatic test_reset_mid();
        int c0, d0, h0, p0, popped;
        logic [DW-1:0] e;
        rdy_mode = 0;
        for (int i = 0; i < 11; i++) push(8'($urandom));
        repeat (2) @(negedge clk);
        h0 = rx.size(); p0 = pop_cnt;
        start_burst(7, c0);
        for (int i = 0; i < 50 && rx.size() - h0 < 3; i++) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        n_cmp++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_m_valid: got %b want 0", m_valid); end
        n_cmp++; if (m_data !== '0) begin n_fail++; $display("FAIL rstmid_m_data: got %h want 00", m_data); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        n_cmp++; if (words_sent !== '0) begin n_fail++; $display("FAIL rstmid_words_sent: got %0d want 0", words_sent); end
        n_cmp++; if (fifo_read_en !== 1'b0) begin n_fail++; $display("FAIL rstmid_read_en: got %b want 0", fifo_read_en); end
        n_cmp++; if (rx.size() - h0 != 3) begin n_fail++; $display("FAIL rstmid_delivered: got %0d want 3", rx.size() - h0); end
        popped = pop_cnt - p0;
        for (int i = 0; i < popped; i++) begin
            e = mq.pop_front();
            if (i < 3) begin
                n_cmp++;
                if (h0 + i >= rx.size() || rx[h0+i] !== e) begin
                    n_fail++; $display("FAIL rstmid_data[%0d]: got %h want %h", i, (h0 + i < rx.size()) ? rx[h0+i] : 'x, e);
                end
            end
        end
        lost = lost + popped - (rx.size() - h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        d0 = done_cnt; h0 = rx.size();
        start_burst(4, c0);
        wait_done(d0, 100, "rstmid");
        for (int i = 0; i < 4; i++) begin
            e = mq.pop_front();
            n_cmp++;
            if (h0 + i >= rx.size() || rx[h0+i] !== e) begin
                n_fail++; $display("FAIL rstmid_after[%0d]: got %h want %h", i, (h0 + i < rx.size()) ? rx[h0+i] : 'x, e);
            end
        end
        n_cmp++; if (words_sent !== LW'(4)) begin n_fail++; $display("FAIL rstmid_words_after: got %0d want 4", words_sent); end
    endtask

    task automatic test_invariants();
        n_cmp++; if (uf_err != 0) begin n_fail++; $display("FAIL inv_underflow: got %0d events want 0", uf_err); end
        n_cmp++; if (stab_err != 0) begin n_fail++; $display("FAIL inv_stable_data: got %0d events want 0", stab_err); end
        n_cmp++; if (ovf_err != 0) begin n_fail++; $display("FAIL inv_occupancy: got %0d events want 0", ovf_err); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_empty_stall();
        test_zero_len();
        test_restart_ignored();
        test_random();
        test_reset_mid();
        test_invariants();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time exceeded, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end
endmodule
